qkv_drain_reader: RTL and testbench

// Read side of the QKV result SRAM. After the QKV projection pass has finished accumulating,

---
 rtl/qkv_drain_reader_pkg.sv | 40 ++++
 rtl/qkv_drain_reader_requant_sat.sv | 32 +++
 rtl/qkv_drain_reader.sv | 170 +++++++++++++++++
 tb/tb_qkv_drain_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qkv_drain_reader_pkg.sv
// Shared definitions for the QKV result-SRAM drain reader.
// Holds the datapath geometry, SRAM address strides, matrix encodings,
// the drain FSM state encoding and the beat record carried by the output FIFO.
package qkv_drain_reader_pkg;

  localparam int ACC_WIDTH  = 21;              // signed accumulator per SRAM word
  localparam int BIT_WIDTH  = 8;               // requantized element width
  localparam int WORDS      = 4;               // accumulators per SRAM row
  localparam int TOKENS     = 729;             // tokens per matrix
  localparam int CHANNEL    = 64;              // channels per matrix
  localparam int GROUPS     = CHANNEL / WORDS; // channel groups per token
  localparam int ADDR_WIDTH = 16;
  localparam int TOK_W      = 10;
  localparam int GRP_W      = 4;

  localparam logic [ADDR_WIDTH-1:0] TOK_STRIDE = 16'h0300;
  localparam logic [ADDR_WIDTH-1:0] MAT_STRIDE = 16'h3000;

  typedef enum logic [1:0] {
    MAT_Q = 2'd0,
    MAT_K = 2'd1,
    MAT_V = 2'd2
  } mat_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  // One output beat: requantized lanes plus the metadata tag that travels with it.
  typedef struct packed {
    logic                       last;
    logic [1:0]                 mat;
    logic [TOK_W-1:0]           token;
    logic [BIT_WIDTH*WORDS-1:0] data;
  } beat_t;

endpackage

// File: rtl/qkv_drain_reader_requant_sat.sv
// One lane of requantization: rounding arithmetic right shift followed by
// saturation to the signed 8-bit range.
// Ports:
//   acc   in  ACC_WIDTH  signed accumulator
//   shift in  4          right-shift amount (0 = no rounding, no shift)
//   q     out BIT_WIDTH  saturated signed result
module requant_sat
  import qkv_drain_reader_pkg::*;
(
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [3:0]           shift,
  output logic [BIT_WIDTH-1:0] q
);

  // One extra bit so adding the rounding bias can never overflow.
  logic signed [ACC_WIDTH:0] wide;
  logic signed [ACC_WIDTH:0] bias;
  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] shifted;

  always_comb begin
    wide = {acc[ACC_WIDTH-1], acc};
    bias = '0;
    if (shift != 4'd0) bias[shift - 4'd1] = 1'b1;
    sum     = wide + bias;
    shifted = sum >>> shift;
    if (shifted > 22'sd127)       q = 8'h7F;
    else if (shifted < -22'sd128) q = 8'h80;
    else                          q = shifted[BIT_WIDTH-1:0];
  end

endmodule

// File: rtl/qkv_drain_reader.sv
// Read side of the QKV result SRAM. Walks Q, K then V in token-major order,
// requantizes each 4-word row and streams beats to the QK matmul stage.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           1-cycle pulse, accepted only when idle
//   shift_amt       requant shift, latched on accepted start
//   rd_en, rd_addr  SRAM read strobe/address; rd_data is valid the cycle after rd_en
//   out_valid/out_ready/out_data/out_mat/out_token/out_last  output beat stream
//   busy            drain in progress
//   done            1-cycle pulse after the final beat is accepted
// Handshake: a beat transfers on a cycle with out_valid=1 and out_ready=1; while
// out_valid=1 and out_ready=0 every out_* field is held stable, and out_valid
// never drops before the beat has transferred.
module qkv_drain_reader
  import qkv_drain_reader_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [3:0]                 shift_amt,
  output logic                       rd_en,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [ACC_WIDTH*WORDS-1:0] rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BIT_WIDTH*WORDS-1:0] out_data,
  output logic [1:0]                 out_mat,
  output logic [TOK_W-1:0]           out_token,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  drain_state_e state, state_next;

  logic [3:0]       shift_q;
  logic [1:0]       mat_q;
  logic [TOK_W-1:0] tok_q;
  logic [GRP_W-1:0] grp_q;

  // Tag of the read whose data is on rd_data this cycle.
  logic             inflight;
  logic             cap_last;
  logic [1:0]       cap_mat;
  logic [TOK_W-1:0] cap_tok;

  beat_t      fifo_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] fifo_count;

  logic [BIT_WIDTH*WORDS-1:0] cap_data;
  beat_t                      cap_beat, head;
  logic                       issue, final_issue, push, pop;
  logic [ADDR_WIDTH-1:0]      addr;

  for (genvar lane = 0; lane < WORDS; lane++) begin : g_lane
    requant_sat u_requant_sat (
      .acc   (rd_data[lane*ACC_WIDTH +: ACC_WIDTH]),
      .shift (shift_q),
      .q     (cap_data[lane*BIT_WIDTH +: BIT_WIDTH])
    );
  end

  // Credit: FIFO entries plus the outstanding read never exceed the two slots.
  assign issue = (state == ST_RUN) &&
                 (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
  assign final_issue = issue && (mat_q == MAT_V) &&
                       (tok_q == TOK_W'(TOKENS - 1)) && (grp_q == GRP_W'(GROUPS - 1));

  assign addr = ({14'd0, mat_q} * MAT_STRIDE) + ({12'd0, grp_q} * TOK_STRIDE) +
                {6'd0, tok_q};
  assign rd_en   = issue;
  assign rd_addr = issue ? addr : '0;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (final_issue) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (out_valid && out_ready && out_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      shift_q  <= '0;
      mat_q    <= MAT_Q;
      tok_q    <= '0;
      grp_q    <= '0;
      inflight <= 1'b0;
      cap_last <= 1'b0;
      cap_mat  <= '0;
      cap_tok  <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (state == ST_IDLE && start) begin
        shift_q <= shift_amt;
        mat_q   <= MAT_Q;
        tok_q   <= '0;
        grp_q   <= '0;
      end else if (issue) begin
        cap_last <= final_issue;
        cap_mat  <= mat_q;
        cap_tok  <= tok_q;
        if (grp_q == GRP_W'(GROUPS - 1)) begin
          grp_q <= '0;
          if (tok_q == TOK_W'(TOKENS - 1)) begin
            tok_q <= '0;
            mat_q <= (mat_q == MAT_V) ? MAT_Q : mat_q + 2'd1;
          end else begin
            tok_q <= tok_q + 10'd1;
          end
        end else begin
          grp_q <= grp_q + 4'd1;
        end
      end
    end
  end

  assign cap_beat = '{last: cap_last, mat: cap_mat, token: cap_tok, data: cap_data};

  // With the FIFO empty the freshly read beat is presented directly, which is
  // what lets a single outstanding read sustain one beat per cycle.
  always_comb begin
    head = '0;
    if (fifo_count != 2'd0) head = fifo_mem[rd_ptr];
    else if (inflight)      head = cap_beat;
  end

  assign out_valid = (fifo_count != 2'd0) || inflight;
  assign pop       = (fifo_count != 2'd0) && out_ready;
  assign push      = inflight && !((fifo_count == 2'd0) && out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= cap_beat;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_data  = head.data;
  assign out_mat   = head.mat;
  assign out_token = head.token;
  assign out_last  = head.last;

endmodule

// File: tb/tb_qkv_drain_reader.sv
// Self-checking bench for qkv_drain_reader: requant vectors, full drain with
// out_ready high, random back-pressure, long stall, start-while-busy and
// mid-drain reset.
module tb_qkv_drain_reader;

  localparam int BEAT_W = 45;
  localparam int TOTAL  = 3 * 729 * 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  shift_amt;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [83:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mat;
  logic [9:0]  out_token;
  logic        out_last;
  logic        busy;
  logic        done;

  qkv_drain_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shift_amt (shift_amt),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mat   (out_mat),
    .out_token (out_token),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  bit          tbl_mode = 1'b0;
  logic [83:0] test_row = '0;

  function automatic logic [20:0] lane_val(input logic [15:0] a, input int k);
    return 21'((int'(a) * 613) ^ (k * 32'h000AB3C5));
  endfunction

  function automatic logic [83:0] make_row(input logic [15:0] a);
    logic [83:0] r;
    for (int k = 0; k < 4; k++) r[k*21 +: 21] = lane_val(a, k);
    return r;
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= tbl_mode ? test_row : make_row(rd_addr);

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_rq(input logic [20:0] a, input int s);
    int v;
    v = int'($signed({{11{a[20]}}, a}));
    if (s > 0) v = (v + (1 << (s - 1))) >>> s;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [15:0] exp_addr(input int idx);
    int g, t, m;
    g = idx % 16;
    t = (idx / 16) % 729;
    m = idx / (16 * 729);
    return 16'(m * 'h3000 + g * 'h300 + t);
  endfunction

  function automatic logic [BEAT_W-1:0] exp_beat(input int idx, input int s);
    logic [15:0] a;
    logic [31:0] d;
    int t, m;
    a = exp_addr(idx);
    t = (idx / 16) % 729;
    m = idx / (16 * 729);
    for (int k = 0; k < 4; k++) d[k*8 +: 8] = ref_rq(lane_val(a, k), s);
    return {(idx == TOTAL - 1), 2'(m), 10'(t), d};
  endfunction

  // ---------------- scoreboard ----------------
  logic [BEAT_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit                mon_on = 1'b0;
  int                rd_idx, acc_cnt, done_cnt, cyc, last_cyc;
  bit                held_valid;
  logic [BEAT_W-1:0] held;

  task automatic monitor();
    logic [BEAT_W-1:0] beat, e;
    int outstanding;
    beat = {out_last, out_mat, out_token, out_data};
    if (mon_on && !reset) begin
      outstanding = rd_idx - acc_cnt;
      if (rd_en) begin
        check("credit", 64'(outstanding >= 2), 64'd0);
        check("rd_addr", rd_addr, exp_addr(rd_idx));
        rd_idx++;
      end
      if (held_valid) check("hold", {out_valid, beat}, {1'b1, held});
      held_valid = out_valid && !out_ready;
      held       = beat;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat", beat, e);
        end
        acc_cnt++;
        if (out_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_lat", 64'(cyc - last_cyc), 64'd1);
      end
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input int s);
    exp_q.delete();
    rd_idx     = 0;
    acc_cnt    = 0;
    done_cnt   = 0;
    held_valid = 1'b0;
    last_cyc   = -10;
    for (int i = 0; i < n; i++) exp_q.push_back(exp_beat(i, s));
    mon_on = 1'b1;
  endtask

  task automatic pulse_start(input logic [3:0] s);
    start     = 1'b1;
    shift_amt = s;
    cycle();
    start     = 1'b0;
    shift_amt = 4'd0;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic rq_case(input string tag, input logic [83:0] row, input logic [3:0] s,
                         input logic [31:0] exp);
    bit seen;
    tbl_mode  = 1'b1;
    test_row  = row;
    out_ready = 1'b0;
    pulse_start(s);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_valid"}, 64'(seen), 64'd1);
    check(tag, out_data, exp);
    @(posedge clk);
    #1;
    do_reset();
    tbl_mode = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    shift_amt = 4'd0;
    out_ready = 1'b0;

    @(negedge clk);
    check("reset_ctrl", {rd_en, out_valid, busy, done, out_last}, 5'd0);
    check("reset_data", {rd_addr, out_data, out_mat, out_token}, 60'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Requant vectors (lane0 in the low bits of the row and of out_data).
    rq_case("rq_s4", {21'h0FFFFF, 21'h1FFFFF, 21'h000188, 21'h000180}, 4'd4, 32'h7F001918);
    rq_case("rq_s1", {21'h000100, 21'h1FFFFD, 21'h000003, 21'h1FFFFF}, 4'd1, 32'h7FFF0200);
    rq_case("rq_s0", {21'h1FFF80, 21'h00007F, 21'h100000, 21'h0FFFFF}, 4'd0, 32'h807F807F);

    // Full drain, out_ready high, with a second start (new shift) while busy.
    start_run(TOTAL, 12);
    out_ready = 1'b1;
    pulse_start(4'd12);
    cycle();
    check("first_rd_lat", 64'(rd_idx), 64'd1);
    check("first_beat_lat0", 64'(acc_cnt), 64'd0);
    cycle();
    check("first_beat_lat1", 64'(acc_cnt), 64'd1);
    for (int i = 0; i < 36000 && done_cnt == 0; i++) begin
      if (i == 500) begin
        start     = 1'b1;
        shift_amt = 4'd3;
      end else if (i == 501) begin
        start     = 1'b0;
        shift_amt = 4'd0;
      end
      cycle();
    end
    repeat (3) cycle();
    check("full_beats", 64'(acc_cnt), 64'(TOTAL));
    check("full_reads", 64'(rd_idx), 64'(TOTAL));
    check("full_q_empty", 64'(exp_q.size()), 64'd0);
    check("full_done_cnt", 64'(done_cnt), 64'd1);
    check("full_idle", {busy, out_valid, rd_en}, 3'd0);
    do_reset();

    // Random back-pressure over the first 1500 beats.
    start_run(1500, 5);
    out_ready = 1'b0;
    pulse_start(4'd5);
    for (int i = 0; i < 8000 && acc_cnt < 1500; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    check("rand_beats", 64'(acc_cnt), 64'd1500);
    do_reset();

    // Stall right after the first beat appears.
    start_run(40, 12);
    out_ready = 1'b0;
    pulse_start(4'd12);
    repeat (22) cycle();
    check("stall_reads", 64'(rd_idx), 64'd2);
    check("stall_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && acc_cnt < 40; i++) cycle();
    check("stall_beats", 64'(acc_cnt), 64'd40);
    do_reset();

    // Reset at beat 100, then restart from the beginning.
    start_run(100, 12);
    out_ready = 1'b1;
    pulse_start(4'd12);
    for (int i = 0; i < 300 && acc_cnt < 100; i++) cycle();
    check("pre_reset_beats", 64'(acc_cnt), 64'd100);
    mon_on = 1'b0;
    reset  = 1'b1;
    #1;
    check("abort_ctrl", {rd_en, out_valid, busy, done, out_last}, 5'd0);
    check("abort_data", {rd_addr, out_data, out_mat, out_token}, 60'd0);
    do_reset();
    start_run(20, 12);
    pulse_start(4'd12);
    for (int i = 0; i < 100 && acc_cnt < 20; i++) cycle();
    check("restart_beats", 64'(acc_cnt), 64'd20);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
